// File: rtl/step_sequencer_if.sv
// Phase-sequencer bus: debug/run control and memory status in, phase enables, status and performance counters out.
// The master side is the CPU/debug controller; the slave side is step_sequencer.
interface step_sequencer_if #(
  parameter int CNT_W = 32
);
  logic             run;
  logic             step_req;
  logic             halt_req;
  logic             mem_access;
  logic             mem_wait;
  logic             fetch_en;
  logic             decode_en;
  logic             exec_en;
  logic             mem_en;
  logic             wb_en;
  logic             pc_we;
  logic             retire;
  logic             busy;
  logic             halted;
  logic [CNT_W-1:0] retire_cnt;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output run, step_req, halt_req, mem_access, mem_wait,
    input  fetch_en, decode_en, exec_en, mem_en, wb_en,
    input  pc_we, retire, busy, halted, retire_cnt, stall_cnt
  );

  modport slave (
    input  run, step_req, halt_req, mem_access, mem_wait,
    output fetch_en, decode_en, exec_en, mem_en, wb_en,
    output pc_we, retire, busy, halted, retire_cnt, stall_cnt
  );
endinterface

// File: rtl/step_sequencer.sv
// Moore phase sequencer (IF/ID/EX/MEM/WB) with boot/inter-instruction gaps, memory stretch and run/halt/step.
// Define STEP_SEQ_PERF_EN to implement retire_cnt/stall_cnt; otherwise both read 0.
module step_sequencer #(
  parameter int IDLE_INIT = 7,
  parameter int IDLE_RUN  = 3,
  parameter int CNT_W     = 32
) (
  input  logic             clk,
  input  logic             reset,
  step_sequencer_if.slave  bus
);

  typedef enum logic [2:0] {
    S_BOOT, S_HALTED, S_IF, S_ID, S_EX, S_MEM, S_WB, S_GAP
  } state_t;

  localparam int IW = 16;
  localparam logic [IW-1:0] INIT_LAST = (IDLE_INIT > 0) ? IW'(IDLE_INIT - 1) : '0;
  localparam logic [IW-1:0] RUN_LAST  = (IDLE_RUN  > 0) ? IW'(IDLE_RUN  - 1) : '0;

  state_t        state_q, state_d;
  logic          stop_q, stop_d, stop_now;
  logic [IW-1:0] idle_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_BOOT;
      stop_q  <= 1'b0;
      idle_q  <= '0;
    end else begin
      state_q <= state_d;
      stop_q  <= stop_d;
      // Idle counter restarts on every state change and only advances while waiting in BOOT or GAP.
      if (state_d == state_q && (state_q == S_BOOT || state_q == S_GAP))
        idle_q <= idle_q + IW'(1);
      else
        idle_q <= '0;
    end
  end

  always_comb begin
    state_d       = state_q;
    stop_now      = stop_q;
    bus.fetch_en  = 1'b0;
    bus.decode_en = 1'b0;
    bus.exec_en   = 1'b0;
    bus.mem_en    = 1'b0;
    bus.wb_en     = 1'b0;
    bus.pc_we     = 1'b0;
    bus.retire    = 1'b0;
    bus.busy      = 1'b0;
    bus.halted    = 1'b0;

    // A halt request or dropped run seen this cycle counts immediately, so WB/GAP react without delay.
    if (state_q != S_BOOT && state_q != S_HALTED && (bus.halt_req || !bus.run))
      stop_now = 1'b1;
    stop_d = stop_now;

    case (state_q)
      S_BOOT: begin
        if (idle_q == INIT_LAST)
          state_d = bus.run ? S_IF : S_HALTED;
      end
      S_HALTED: begin
        bus.halted = 1'b1;
        if (bus.run) begin
          state_d = S_IF;
          stop_d  = 1'b0;
        end else if (bus.step_req) begin
          state_d = S_IF;
          stop_d  = 1'b1;
        end
      end
      S_IF: begin
        bus.fetch_en = 1'b1;
        bus.busy     = 1'b1;
        state_d      = S_ID;
      end
      S_ID: begin
        bus.decode_en = 1'b1;
        bus.busy      = 1'b1;
        state_d       = S_EX;
      end
      S_EX: begin
        bus.exec_en = 1'b1;
        bus.busy    = 1'b1;
        state_d     = S_MEM;
      end
      S_MEM: begin
        bus.mem_en = 1'b1;
        bus.busy   = 1'b1;
        if (!(bus.mem_access && bus.mem_wait))
          state_d = S_WB;
      end
      S_WB: begin
        bus.wb_en  = 1'b1;
        bus.pc_we  = 1'b1;
        bus.retire = 1'b1;
        bus.busy   = 1'b1;
        if (stop_now) begin
          state_d = S_HALTED;
          stop_d  = 1'b0;
        end else if (IDLE_RUN == 0) begin
          state_d = S_IF;
        end else begin
          state_d = S_GAP;
        end
      end
      S_GAP: begin
        if (stop_now) begin
          state_d = S_HALTED;
          stop_d  = 1'b0;
        end else if (idle_q == RUN_LAST) begin
          state_d = S_IF;
        end
      end
      default: state_d = S_BOOT;
    endcase
  end

`ifdef STEP_SEQ_PERF_EN
  logic [CNT_W-1:0] retire_q;
  logic [CNT_W-1:0] stall_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      retire_q <= '0;
      stall_q  <= '0;
    end else begin
      if (state_q == S_WB)
        retire_q <= retire_q + CNT_W'(1);
      if (state_q == S_MEM && bus.mem_access && bus.mem_wait)
        stall_q <= stall_q + CNT_W'(1);
    end
  end

  assign bus.retire_cnt = retire_q;
  assign bus.stall_cnt  = stall_q;
`else
  assign bus.retire_cnt = {CNT_W{1'b0}};
  assign bus.stall_cnt  = {CNT_W{1'b0}};
`endif

endmodule

// File: doc/step_sequencer.md
# step_sequencer

Multicycle phase sequencer for the CPU datapath. It replaces the free-running step toggle with a Moore state machine that issues one-hot phase enables (fetch, decode, execute, memory, writeback) to the PC, register file, ALU and data memory. It inserts boot and inter-instruction idle gaps, stretches the memory phase on memory wait, and provides run/halt/single-step control for debug. It sits in cpu_top between the clock/reset and every stateful datapath element.

## Interface
- IDLE_INIT, 7: idle cycles after reset release before the first fetch.
- IDLE_RUN, 3: idle cycles between writeback and the next fetch; 0 means back-to-back instructions.
- CNT_W, 32: width of the performance counters.

- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  synchronous, active-low (0 = reset asserted).
- run  in  1  level; 1 = free-run, 0 = request halt at the next instruction boundary.
- step_req  in  1  one-cycle pulse; executes exactly one instruction while halted.
- halt_req  in  1  one-cycle pulse; halts after the current instruction.
- mem_access  in  1  current instruction uses data memory (mem_rd|mem_wr).
- mem_wait  in  1  data memory not ready; sampled only in MEM when mem_access=1.
- fetch_en, decode_en, exec_en, mem_en, wb_en  out  1 each  one-hot phase enables.
- pc_we  out  1  PC update strobe; equals wb_en.
- retire  out  1  one-cycle pulse per completed instruction; equals wb_en.
- busy  out  1  high in IF/ID/EX/MEM/WB.
- halted  out  1  high in HALTED.
- retire_cnt  out  CNT_W  instructions retired.
- stall_cnt  out  CNT_W  cycles spent stretched in MEM.

## Operation
- States: BOOT, HALTED, IF, ID, EX, MEM, WB, GAP. The state is registered. All phase/status outputs decode the state only (Moore).
- BOOT: idle counter counts IDLE_INIT cycles. Then go to IF if run=1, else HALTED.
- IF→ID→EX→MEM, one cycle each.
- MEM: stay while mem_access=1 and mem_wait=1; each such cycle increments stall_cnt. Otherwise go to WB. mem_wait is ignored when mem_access=0.
- WB: retire_cnt += 1.
  - If the stop flag is set, go to HALTED and clear stop and the single-step flag.
  - Else if IDLE_RUN=0, go to IF.
  - Else go to GAP.
- GAP: count IDLE_RUN cycles, then go to IF.
- Stop flag:
  - Set by halt_req in any state except BOOT/HALTED.
  - Set by run=0 sampled during IF..WB or GAP.
  - If the flag is set while in GAP, GAP exits immediately to HALTED with no further fetch.
- HALTED:
  - run=1 → IF.
  - step_req=1 → IF with the stop flag pre-set, so exactly one instruction executes, then HALTED.
  - halt_req in HALTED is ignored.
  - If run=1 and step_req=1 together, run wins (free-run).
- step_req outside HALTED is ignored.
- Counters wrap modulo 2^CNT_W.

## Timing
- While reset=0: state=BOOT, idle counter=0, stop flag=0, counters=0, all enables/retire/busy/halted=0.
- Cycle numbering: cycle 0 is the first cycle with reset=1.
- With defaults: BOOT occupies cycles 0..6 and fetch_en is high in cycle 7.
- Instruction latency is 5 cycles plus stall cycles. Fetch-to-fetch period is 5+IDLE_RUN+stalls (8 with defaults).
- Inputs are sampled at the rising edge, and the effect appears in the next state (one-cycle response).
- Reset asserted mid-instruction aborts immediately to BOOT. No wb_en or pc_we is issued for the aborted instruction.
- Exactly one of the five phase enables is high in IF..WB; none are high in BOOT/GAP/HALTED.

## Configuration
- STEP_SEQ_PERF_EN defined: retire_cnt and stall_cnt are implemented as above.
- Not defined: both counters and their registers are removed, and the outputs are tied to 0. Sequencing is unchanged.

## Test plan
- Boot: release reset with run=1 and defaults → fetch_en high in cycles 7, 15, 23. wb_en/pc_we/retire high in cycles 11, 19, 27. retire_cnt=3 after cycle 27.
- Memory stall: run=1, mem_access=1, mem_wait=1 for 4 MEM cycles → MEM held 5 cycles, wb_en delayed 4 cycles, stall_cnt=4. Repeat with mem_access=0 and mem_wait=1 → no stretch, stall_cnt unchanged.
- Halt: pulse halt_req during EX of instruction N → N reaches WB, then halted=1 with no further fetch_en. Pulse halt_req in GAP → HALTED next cycle, retire_cnt unchanged.
- Single step: boot with run=0 → halted=1 from cycle 7. Pulse step_req → one IF..WB sequence, retire_cnt +1, back to halted. step_req pulsed during busy is ignored.
- Reset mid-operation: drive reset=0 during MEM → next cycle all outputs 0 and state BOOT. On release, the first fetch_en arrives after IDLE_INIT cycles and counters restart from 0.
- IDLE_RUN=0 build: fetch_en immediately follows wb_en, period 5. Without STEP_SEQ_PERF_EN, retire_cnt and stall_cnt read 0 throughout.
